// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch (i_*) and load/store (d_*).
// Data wins ties, a streak counter stops fetch starving, and a watchdog bounds each access.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int TIMEOUT      = 16,
  parameter int MAX_D_STREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          err,
  output logic          busy
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state, state_nx;
  logic            gnt_d;
  logic [SW-1:0]   streak;
  logic [TW-1:0]   tcnt;
  logic [DW-1:0]   rdata_q;
  logic            err_q;
  logic            pick_d;
  logic            timeout;
  logic            any_req;

  always_comb begin
    any_req  = i_req | d_req;
    pick_d   = d_req & ~(i_req & (streak == SW'(MAX_D_STREAK)));
    // Last permitted silent cycle: abort instead of counting further.
    timeout  = (tcnt == TW'(TIMEOUT - 1)) & ~mem_ack;
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = BUSY;
      BUSY:    if (mem_ack || timeout) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt_d     <= 1'b0;
      streak    <= '0;
      tcnt      <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (any_req) begin
          gnt_d     <= pick_d;
          mem_req   <= 1'b1;
          mem_we    <= pick_d & d_we;
          mem_addr  <= pick_d ? d_addr : i_addr;
          mem_wdata <= pick_d ? d_wdata : '0;
          tcnt      <= '0;
          // Streak only grows while fetch is actually being passed over.
          if (pick_d && i_req) begin
            if (streak != SW'(MAX_D_STREAK)) streak <= streak + SW'(1);
          end else begin
            streak <= '0;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            rdata_q <= mem_we ? '0 : mem_rdata;
            err_q   <= 1'b0;
          end else if (timeout) begin
            mem_req <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy    = (state != IDLE);
    i_ack   = (state == RESP) & ~gnt_d;
    d_ack   = (state == RESP) &  gnt_d;
    err     = (state == RESP) &  err_q;
    i_rdata = i_ack ? rdata_q : '0;
    d_rdata = d_ack ? rdata_q : '0;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random traffic on both requesters plus a scheduled memory responder, checked every
// cycle against a transaction-level prediction of grant order, latency and data.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, TIMEOUT = 16, MAXS = 4;

  logic          clk, reset;
  logic          i_req, d_req, d_we, mem_ack;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic          i_ack, d_ack, mem_req, mem_we, err, busy;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model state: one outstanding transaction described by its timeline.
  int            cyc = 0, next_free = 0, streak = 0;
  bit            have_tr = 0;
  int            t0, tr_end, ack_at;
  bit            tr_d, tr_we, tr_err;
  logic [AW-1:0] tr_addr;
  logic [DW-1:0] tr_wdata, tr_rdata, rd;
  bit            i_done = 0, d_done = 0, i_held = 0, d_held = 0;
  int            n_i = 0, n_d = 0, n_to = 0;

  task automatic step();
    int  n;
    bit  gd, exp_mreq, exp_resp, exp_busy;
    @(posedge clk); #1; cyc++;
    if (i_done) begin
      i_done = 0; i_held = 0;
      i_req = ($urandom_range(0, 3) != 0); i_addr = $urandom;
    end else if (!i_req) begin
      if ($urandom_range(0, 2) == 0) begin i_req = 1; i_addr = $urandom; end
    end else if (!i_held && $urandom_range(0, 3) == 0) i_addr = $urandom;
    if (d_done) begin
      d_done = 0; d_held = 0;
      d_req = ($urandom_range(0, 3) != 0);
      d_addr = $urandom; d_wdata = $urandom; d_we = $urandom_range(0, 1);
    end else if (!d_req) begin
      if ($urandom_range(0, 2) == 0) begin
        d_req = 1; d_addr = $urandom; d_wdata = $urandom; d_we = $urandom_range(0, 1);
      end
    end else if (!d_held && $urandom_range(0, 3) == 0) begin
      d_addr = $urandom; d_wdata = $urandom; d_we = $urandom_range(0, 1);
    end

    if (cyc >= next_free && (i_req || d_req)) begin
      gd = d_req && !(i_req && streak == MAXS);
      if (gd && i_req) streak = (streak < MAXS) ? streak + 1 : MAXS;
      else             streak = 0;
      have_tr  = 1; t0 = cyc; tr_d = gd;
      tr_we    = gd ? d_we : 1'b0;
      tr_addr  = gd ? d_addr : i_addr;
      tr_wdata = d_wdata;
      if (gd) begin d_held = 1; n_d++; end else begin i_held = 1; n_i++; end
      if ($urandom_range(0, 7) == 0) begin
        tr_err = 1; ack_at = -1; tr_end = cyc + TIMEOUT + 1; tr_rdata = '0; n_to++;
      end else begin
        n = $urandom_range(1, 5);
        tr_err = 0; ack_at = cyc + n; tr_end = ack_at + 1;
        rd = $urandom; tr_rdata = tr_we ? '0 : rd;
      end
      next_free = tr_end + 1;
    end

    if (have_tr && cyc == ack_at) begin
      mem_ack = 1; mem_rdata = rd;
    end else begin
      mem_rdata = $urandom;
      // Stray acks are only legal while no access is outstanding downstream.
      mem_ack = !(have_tr && cyc > t0 && cyc < tr_end) && ($urandom_range(0, 4) == 0);
    end

    @(negedge clk);
    exp_busy = have_tr && cyc > t0 && cyc <= tr_end;
    exp_mreq = have_tr && cyc > t0 && cyc < tr_end;
    exp_resp = have_tr && cyc == tr_end;
    chk("busy", busy, exp_busy);
    chk("mem_req", mem_req, exp_mreq);
    if (exp_mreq) begin
      chk("mem_addr", mem_addr, tr_addr);
      chk("mem_we", mem_we, tr_we);
      if (tr_we) chk("mem_wdata", mem_wdata, tr_wdata);
    end
    chk("i_ack", i_ack, exp_resp && !tr_d);
    chk("d_ack", d_ack, exp_resp && tr_d);
    chk("i_rdata", i_rdata, (exp_resp && !tr_d) ? tr_rdata : '0);
    chk("d_rdata", d_rdata, (exp_resp && tr_d) ? tr_rdata : '0);
    chk("err", err, exp_resp && tr_err);
    if (exp_resp) begin
      if (tr_d) d_done = 1; else i_done = 1;
    end
  endtask

  task automatic model_reset();
    have_tr = 0; streak = 0; next_free = 0;
    i_done = 0; d_done = 0; i_held = 0; d_held = 0;
  endtask

  initial begin
    bit found;
    reset = 1; i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acks", {i_ack, d_ack, err}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;

    repeat (1500) step();

    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      step();
      if (have_tr && cyc > t0 && cyc < tr_end - 1) found = 1;
    end
    chk("find_busy", found, 1);
    #2 reset = 1;
    #1;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_acks", {i_ack, d_ack, err}, 0);
    i_req = 0; d_req = 0; mem_ack = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;

    repeat (1500) step();

    chk("saw_fetch", n_i > 20, 1);
    chk("saw_data", n_d > 20, 1);
    chk("saw_timeout", n_to > 5, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
